// File: rtl/servant_ram_pkg.sv
// Shared types and constants for the servant RAM arbiter: FSM states,
// port indices and the debug view of the controller.
package servant_ram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic PORT_IBUS = 1'b0;
  localparam logic PORT_DBUS = 1'b1;

  typedef struct packed {
    state_t     state;
    logic [2:0] cnt;
    logic       winner;
  } dbg_t;

endpackage

// File: rtl/servant_ram_rr_arb.sv
// Two-request round-robin arbiter: one-hot grant, registered pointer to the
// port granted last. Out of reset the instruction bus counts as last.
module servant_ram_rr_arb
  import servant_ram_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last;

  always_comb begin
    gnt = 2'b00;
    if (req[PORT_IBUS] && req[PORT_DBUS]) begin
      if (last == PORT_DBUS) gnt[PORT_IBUS] = 1'b1;
      else                   gnt[PORT_DBUS] = 1'b1;
    end else begin
      gnt = req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= PORT_IBUS;
    end else if (en && (req != 2'b00)) begin
      last <= gnt[PORT_DBUS] ? PORT_DBUS : PORT_IBUS;
    end
  end

endmodule

// File: rtl/servant_ram_arb.sv
// Single-port word RAM shared by the instruction and data buses through a
// round-robin arbiter and an IDLE/BUSY/ACK access sequencer.
module servant_ram_arb
  import servant_ram_pkg::*;
#(
  parameter int depth   = 256,
  parameter int aw      = $clog2(depth),
  parameter     memfile = "",
  parameter int WAIT    = 0
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst,
  input  logic [29:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  input  logic [29:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  output dbg_t        o_dbg
);

  localparam int WORDS = depth / 4;
  localparam int WW    = aw - 2;

  logic [31:0] mem [WORDS];

  state_t          state;
  logic [2:0]      cnt;
  logic            winner;
  logic [WW-1:0]   lat_idx;
  logic [31:0]     lat_dat;
  logic [3:0]      lat_sel;
  logic            lat_we;
  logic [1:0]      req;
  logic [1:0]      gnt;
  logic            grant_en;
  logic            do_access;
  logic            unused_adr;

  assign req       = {i_dbus_cyc, i_ibus_cyc};
  assign grant_en  = !i_wb_rst && (state == IDLE);
  assign do_access = (state == BUSY) && (cnt == 3'd0);

  // Upper address bits alias onto the array and are intentionally dropped.
  assign unused_adr = ^{i_ibus_adr[29:WW], i_dbus_adr[29:WW]};

  assign o_dbg = '{state: state, cnt: cnt, winner: winner};

  servant_ram_rr_arb u_rr (
    .clk (i_wb_clk),
    .rst (i_wb_rst),
    .req (req),
    .en  (grant_en),
    .gnt (gnt)
  );

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = 32'h0;
  end

  // Memory is never reset; the write is gated so a reset mid-access drops it.
  always_ff @(posedge i_wb_clk) begin
    if (!i_wb_rst && do_access && lat_we) begin
      for (int n = 0; n < 4; n++) begin
        if (lat_sel[n]) mem[lat_idx][n*8 +: 8] <= lat_dat[n*8 +: 8];
      end
    end
  end

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      o_ibus_ack <= 1'b0;
      o_dbus_ack <= 1'b0;
      o_ibus_rdt <= 32'h0;
      o_dbus_rdt <= 32'h0;
    end else begin
      o_ibus_ack <= 1'b0;
      o_dbus_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            if (gnt[PORT_DBUS]) begin
              winner  <= PORT_DBUS;
              lat_idx <= i_dbus_adr[WW-1:0];
              lat_dat <= i_dbus_dat;
              lat_sel <= i_dbus_sel;
              lat_we  <= i_dbus_we;
            end else begin
              winner  <= PORT_IBUS;
              lat_idx <= i_ibus_adr[WW-1:0];
              lat_dat <= 32'h0;
              lat_sel <= 4'h0;
              lat_we  <= 1'b0;
            end
            cnt   <= 3'(WAIT);
            state <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else begin
            // Read returns the word as it was before any write this access.
            if (winner == PORT_DBUS) begin
              o_dbus_rdt <= mem[lat_idx];
              o_dbus_ack <= 1'b1;
            end else begin
              o_ibus_rdt <= mem[lat_idx];
              o_ibus_ack <= 1'b1;
            end
            state <= ACK;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_servant_ram_arb.sv
// Bench for servant_ram_arb: a WAIT=0 instance checked against a word-array
// reference model and a WAIT=3 instance for latency and wait-counter sweep.
module tb_servant_ram_arb;
  import servant_ram_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [29:0] ibus_adr = '0;
  logic        ibus_cyc = 1'b0;
  logic [31:0] ibus_rdt;
  logic        ibus_ack;
  logic [29:0] dbus_adr = '0;
  logic [31:0] dbus_dat = '0;
  logic [3:0]  dbus_sel = '0;
  logic        dbus_we  = 1'b0;
  logic        dbus_cyc = 1'b0;
  logic [31:0] dbus_rdt;
  logic        dbus_ack;
  dbg_t        dbg;

  logic [29:0] w3_ibus_adr = '0;
  logic        w3_ibus_cyc = 1'b0;
  logic [31:0] w3_ibus_rdt;
  logic        w3_ibus_ack;
  logic [29:0] w3_dbus_adr = '0;
  logic [31:0] w3_dbus_dat = '0;
  logic [3:0]  w3_dbus_sel = '0;
  logic        w3_dbus_we  = 1'b0;
  logic        w3_dbus_cyc = 1'b0;
  logic [31:0] w3_dbus_rdt;
  logic        w3_dbus_ack;
  dbg_t        w3_dbg;

  int checks = 0;
  int errors = 0;

  // Reference model: 64-word array, per-port expected read data, last grant.
  logic [31:0] m_mem [64];
  logic [31:0] exp_rdt [2];
  bit          m_last;
  logic [31:0] exp_q [$];
  logic [31:0] grant_log [$];

  logic [29:0] op_adr [2];
  logic [31:0] op_dat;
  logic [3:0]  op_sel;
  logic        op_we;

  always #5 clk = ~clk;

  servant_ram_arb #(.depth(256), .memfile(""), .WAIT(0)) dut (
    .i_wb_clk(clk), .i_wb_rst(rst),
    .i_ibus_adr(ibus_adr), .i_ibus_cyc(ibus_cyc), .o_ibus_rdt(ibus_rdt), .o_ibus_ack(ibus_ack),
    .i_dbus_adr(dbus_adr), .i_dbus_dat(dbus_dat), .i_dbus_sel(dbus_sel), .i_dbus_we(dbus_we),
    .i_dbus_cyc(dbus_cyc), .o_dbus_rdt(dbus_rdt), .o_dbus_ack(dbus_ack), .o_dbg(dbg)
  );

  servant_ram_arb #(.depth(256), .memfile(""), .WAIT(3)) dut_w3 (
    .i_wb_clk(clk), .i_wb_rst(rst),
    .i_ibus_adr(w3_ibus_adr), .i_ibus_cyc(w3_ibus_cyc), .o_ibus_rdt(w3_ibus_rdt), .o_ibus_ack(w3_ibus_ack),
    .i_dbus_adr(w3_dbus_adr), .i_dbus_dat(w3_dbus_dat), .i_dbus_sel(w3_dbus_sel), .i_dbus_we(w3_dbus_we),
    .i_dbus_cyc(w3_dbus_cyc), .o_dbus_rdt(w3_dbus_rdt), .o_dbus_ack(w3_dbus_ack), .o_dbg(w3_dbg)
  );

  task automatic model_access(input int p);
    int idx;
    logic [31:0] old;
    idx = int'(op_adr[p] % 30'd64);
    old = m_mem[idx];
    if (p == 1 && op_we) begin
      for (int n = 0; n < 4; n++)
        if (op_sel[n]) m_mem[idx][n*8 +: 8] = op_dat[n*8 +: 8];
    end
    exp_rdt[p] = old;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; ibus_cyc = 1'b0; dbus_cyc = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_rdt[0] = 32'h0; exp_rdt[1] = 32'h0; m_last = 1'b0;
  endtask

  // One round: chosen ports request together and hold cyc until acked.
  task automatic run_round(input bit want_i, input bit want_d, input int lat);
    bit pend [2];
    int n, first_n, p, exp_p, exp_n;
    logic [1:0] acks;
    pend[0] = want_i; pend[1] = want_d; n = 0; first_n = -1;
    @(posedge clk); #1;
    ibus_adr = op_adr[0]; ibus_cyc = want_i;
    dbus_adr = op_adr[1]; dbus_dat = op_dat; dbus_sel = op_sel; dbus_we = op_we;
    dbus_cyc = want_d;
    while ((pend[0] || pend[1]) && n < 64) begin
      @(posedge clk); n++;
      @(negedge clk);
      acks = {dbus_ack, ibus_ack};
      if (acks == 2'b11) begin
        checks++; errors++;
        $display("FAIL ack_overlap: both acks high at cycle %0d", n);
        pend[0] = 0; pend[1] = 0;
      end else if (acks != 2'b00) begin
        p = acks[1] ? 1 : 0;
        exp_p = (pend[0] && pend[1]) ? (m_last ? 0 : 1) : (pend[1] ? 1 : 0);
        checks++;
        if (p !== exp_p) begin
          errors++;
          $display("FAIL grant_port: got port %0d, expected port %0d", p, exp_p);
        end
        exp_n = (first_n < 0) ? lat : first_n + lat + 1;
        checks++;
        if (n !== exp_n) begin
          errors++;
          $display("FAIL ack_latency: ack after %0d cycles, expected %0d", n, exp_n);
        end
        model_access(p);
        checks++;
        if (ibus_rdt !== exp_rdt[0] || dbus_rdt !== exp_rdt[1]) begin
          errors++;
          $display("FAIL rdt: ibus %08h dbus %08h, expected ibus %08h dbus %08h",
                   ibus_rdt, dbus_rdt, exp_rdt[0], exp_rdt[1]);
        end
        grant_log.push_back(32'(p));
        m_last = (p == 1);
        pend[p] = 0;
        if (p == 1) dbus_cyc = 1'b0; else ibus_cyc = 1'b0;
        if (first_n < 0) first_n = n;
      end
    end
    if (pend[0] || pend[1]) begin
      checks++; errors++;
      $display("FAIL timeout: pending ibus=%0d dbus=%0d, expected none", pend[0], pend[1]);
      ibus_cyc = 1'b0; dbus_cyc = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (ibus_ack !== 1'b0 || dbus_ack !== 1'b0) begin
      errors++;
      $display("FAIL ack_pulse: acks %b%b one cycle after ack, expected 00", ibus_ack, dbus_ack);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ibus_ack, dbus_ack, w3_ibus_ack, w3_dbus_ack} !== 4'b0) begin
      errors++; $display("FAIL reset_ack: %b%b%b%b, expected 0000", ibus_ack, dbus_ack, w3_ibus_ack, w3_dbus_ack);
    end
    checks++;
    if (ibus_rdt !== 32'h0 || dbus_rdt !== 32'h0) begin
      errors++; $display("FAIL reset_rdt: ibus %08h dbus %08h, expected 0", ibus_rdt, dbus_rdt);
    end
    checks++;
    if (dbg.state !== IDLE || dbg.cnt !== 3'd0 || w3_dbg.state !== IDLE || w3_dbg.cnt !== 3'd0) begin
      errors++; $display("FAIL reset_state: state %0d cnt %0d, expected IDLE cnt 0", dbg.state, dbg.cnt);
    end
    @(posedge clk); #1 rst = 1'b0;
    exp_rdt[0] = 32'h0; exp_rdt[1] = 32'h0; m_last = 1'b0;
  endtask

  task automatic test_directed();
    op_adr[1] = 30'h4; op_dat = 32'hDEADBEEF; op_sel = 4'hF; op_we = 1'b1;
    run_round(0, 1, 2);
    op_adr[0] = 30'h4;
    run_round(1, 0, 2);
    checks++;
    if (ibus_rdt !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_read: ibus_rdt %08h, expected deadbeef", ibus_rdt);
    end
    op_adr[1] = 30'h5; op_dat = 32'h11223344; op_sel = 4'hF; op_we = 1'b1;
    run_round(0, 1, 2);
    op_dat = 32'h00AA0000; op_sel = 4'b0100;
    run_round(0, 1, 2);
    checks++;
    if (dbus_rdt !== 32'h11223344) begin
      errors++; $display("FAIL write_prewrite: dbus_rdt %08h, expected 11223344", dbus_rdt);
    end
    op_adr[0] = 30'h5;
    run_round(1, 0, 2);
    checks++;
    if (ibus_rdt !== 32'h11AA3344) begin
      errors++; $display("FAIL byte_lane: ibus_rdt %08h, expected 11aa3344", ibus_rdt);
    end
    op_adr[1] = 30'h0; op_dat = 32'h0BADF00D; op_sel = 4'hF; op_we = 1'b1;
    run_round(0, 1, 2);
    op_adr[0] = 30'h40;
    run_round(1, 0, 2);
    checks++;
    if (ibus_rdt !== 32'h0BADF00D) begin
      errors++; $display("FAIL alias: ibus_rdt %08h, expected 0badf00d", ibus_rdt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    grant_log.delete();
    exp_q = '{32'd1, 32'd0, 32'd1, 32'd0};
    op_adr[0] = 30'h4; op_adr[1] = 30'h5; op_we = 1'b0; op_sel = 4'hF; op_dat = 32'h0;
    run_round(1, 1, 2);
    run_round(1, 1, 2);
    checks++;
    if (grant_log.size() != 4) begin
      errors++; $display("FAIL rr_count: %0d grants, expected 4", grant_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (grant_log[i] !== exp_q[i]) begin
          errors++; $display("FAIL rr_order: grant %0d to port %0d, expected %0d", i, grant_log[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_busy();
    op_adr[1] = 30'h8; op_dat = 32'h12345678; op_sel = 4'hF; op_we = 1'b1;
    run_round(0, 1, 2);
    @(posedge clk); #1;
    dbus_adr = 30'h8; dbus_dat = 32'hCAFEF00D; dbus_sel = 4'hF; dbus_we = 1'b1; dbus_cyc = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; dbus_cyc = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rdt[0] = 32'h0; exp_rdt[1] = 32'h0; m_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (ibus_ack !== 1'b0 || dbus_ack !== 1'b0) begin
        errors++; $display("FAIL reset_busy_ack: acks %b%b, expected 00", ibus_ack, dbus_ack);
      end
    end
    op_adr[0] = 30'h8;
    run_round(1, 0, 2);
    checks++;
    if (ibus_rdt !== 32'h12345678) begin
      errors++; $display("FAIL reset_busy_mem: ibus_rdt %08h, expected 12345678", ibus_rdt);
    end
  endtask

  task automatic test_random();
    bit wi, wd;
    for (int r = 0; r < 40; r++) begin
      wi = 1'($urandom_range(0, 1));
      wd = 1'($urandom_range(0, 1));
      if (!wi && !wd) wd = 1'b1;
      op_adr[0] = 30'($urandom_range(0, 127));
      op_adr[1] = 30'($urandom_range(0, 127));
      op_dat = $urandom;
      op_sel = 4'($urandom_range(0, 15));
      op_we  = 1'($urandom_range(0, 1));
      run_round(wi, wd, 2);
    end
  endtask

  task automatic test_wait3();
    int n, k;
    bit got;
    @(posedge clk); #1;
    w3_dbus_adr = 30'h3; w3_dbus_dat = 32'hA5A55A5A; w3_dbus_sel = 4'hF; w3_dbus_we = 1'b1;
    w3_dbus_cyc = 1'b1;
    n = 0; k = 0; got = 0;
    while (!got && n < 20) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (w3_dbg.state == BUSY) begin
        checks++;
        if (w3_dbg.cnt !== 3'(3 - k)) begin
          errors++; $display("FAIL wait_sweep: step %0d cnt %0d, expected %0d", k, w3_dbg.cnt, 3 - k);
        end
        k++;
      end
      if (w3_dbus_ack) begin
        got = 1; w3_dbus_cyc = 1'b0;
        checks++;
        if (n !== 5) begin
          errors++; $display("FAIL wait_latency: ack after %0d cycles, expected 5", n);
        end
      end
    end
    checks++;
    if (!got || k !== 4) begin
      errors++; $display("FAIL wait_steps: acked %0d, busy steps %0d, expected 1 and 4", got, k);
    end
    @(posedge clk); #1;
    w3_ibus_adr = 30'h43; w3_ibus_cyc = 1'b1;
    n = 0; got = 0;
    while (!got && n < 20) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (w3_ibus_ack) begin
        got = 1; w3_ibus_cyc = 1'b0;
      end
    end
    checks++;
    if (!got || n !== 5 || w3_ibus_rdt !== 32'hA5A55A5A) begin
      errors++; $display("FAIL wait_read: acked %0d after %0d cycles data %08h, expected 1, 5, a5a55a5a",
                         got, n, w3_ibus_rdt);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) m_mem[i] = 32'h0;
    exp_rdt[0] = 32'h0; exp_rdt[1] = 32'h0; m_last = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_busy();
    test_random();
    test_wait3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/servant_ram_arb.md
SERVANT_RAM_ARB -- requirements
Module: servant_ram_arb

Interface
REQ-001 SHALL have parameter depth, default 256, memory size in bytes (multiple of 4, power of 2).
REQ-002 SHALL have parameter aw, default $clog2(depth), byte-address width used for decode.
REQ-003 SHALL have parameter memfile, default "", hex init file; empty means zero-fill.
REQ-004 SHALL have parameter WAIT, default 0, range 0..7, extra wait cycles per access.
REQ-005 SHALL have port i_wb_clk  in  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port i_wb_rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port i_ibus_adr  in  30  instruction fetch word address [31:2].
REQ-008 SHALL have port i_ibus_cyc  in  1  instruction read request.
REQ-009 SHALL have port o_ibus_rdt  out  32  instruction read data.
REQ-010 SHALL have port o_ibus_ack  out  1  instruction ack, one-cycle pulse.
REQ-011 SHALL have ports i_dbus_adr in 30, i_dbus_dat in 32, i_dbus_sel in 4, i_dbus_we in 1, i_dbus_cyc in 1: data bus request.
REQ-012 SHALL have ports o_dbus_rdt out 32, o_dbus_ack out 1: data bus response.

Function
REQ-013 SHALL share one word array of depth/4 x 32 bits between both ports, indexed by adr[aw-1:2]; higher address bits ignored (aliasing).
REQ-014 SHALL implement FSM IDLE -> BUSY -> ACK -> IDLE.
REQ-015 IDLE: on edge with any cyc high, SHALL latch winner's adr/dat/sel/we (ibus we=0), load wait counter with WAIT, go BUSY; otherwise stay IDLE.
REQ-016 Arbitration: single requester wins; both high -> port not granted last time wins (round-robin); pointer updates on every grant.
REQ-017 BUSY: counter>0 -> decrement, stay; counter==0 -> perform access, go ACK.
REQ-018 Access: write byte lane n iff we and sel[n]; read SHALL return pre-write word into winner's rdt register.
REQ-019 ACK state: winner's ack SHALL be high for exactly this cycle, other ack low; next edge -> IDLE.
REQ-020 Latency: ack high in cycle WAIT+2 after cycle in which cyc first sampled in IDLE (WAIT=0 -> 2).
REQ-021 Requests SHALL NOT be sampled in ACK state; earliest next grant is edge after returning to IDLE.
REQ-022 Losing requester SHALL be held (cyc stays high) and granted at the next IDLE sample.
REQ-023 Dropping cyc after grant SHALL NOT abort: latched access completes, ack still pulsed.
REQ-024 rdt of a port SHALL hold its last value until that port's next read completes; writes leave o_dbus_rdt holding pre-write word.
REQ-025 Both acks SHALL never be high in the same cycle.

Reset
REQ-026 While i_wb_rst high at an edge: state IDLE, counter 0, both acks 0, both rdt 32'h0, RR pointer favours dbus first.
REQ-027 Reset mid-BUSY SHALL cancel pending access with no memory write and no ack.
REQ-028 Memory contents SHALL NOT be affected by reset; initial content from memfile or zeros.

Structure
REQ-029 Shared package servant_ram_pkg SHALL hold FSM state enum (IDLE, BUSY, ACK) and port index constants (PORT_IBUS=0, PORT_DBUS=1).
REQ-030 Round-robin grant logic SHALL be sub-module servant_ram_rr_arb (2 requests, grant one-hot, registered last-grant pointer).
REQ-031 Memory array and FSM SHALL reside in servant_ram_arb.

Verification
REQ-032 WAIT=0, dbus write adr 0x4, dat 0xDEADBEEF, sel 4'hF -> dbus ack 2 cycles later; ibus read adr 0x4 -> rdt 0xDEADBEEF.
REQ-033 Byte lanes: word 0x11223344, write sel 4'b0100 dat 0x00AA0000 -> read 0x11AA3344.
REQ-034 Both cyc high every cycle from reset -> grants dbus, ibus, dbus, ibus; acks never overlap.
REQ-035 WAIT=3 -> ack exactly 5 cycles after request; counter sweep 3,2,1,0.
REQ-036 Reset asserted in BUSY of write 0xCAFEF00D to adr 0x8 -> no ack; later read adr 0x8 returns prior value.
REQ-037 depth=256, read adr 0x40 (word 64) -> aliases to word 0; returns mem[0].
